// File: rtl/spindle_pkg.sv
// Shared constants and helpers for the spindle afferent path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spindle_pkg;

    // IEEE-754 single-precision field layout
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    // Integer bits of the unsigned fixed-point rate (rates below 2^17 pps)
    localparam int INT_W    = 17;

    localparam logic [31:0] IEEE_100000 = 32'h47C3_5000;
    localparam logic [31:0] IEEE_ZERO   = 32'h0000_0000;

    // Accumulator threshold: one full phase turn, in rate fixed-point units
    function automatic int thresh(input int tick_hz, input int frac_w);
        return tick_hz << frac_w;
    endfunction

endpackage

// File: rtl/float_to_ufix.sv
// Combinational IEEE-754 single -> UQ17.FRAC_W, truncating toward zero.
// Latency: 0 cycles (pure combinational; the parent registers around it).
// Backpressure: none. Negatives, zero, denormals, NaN -> 0; +inf or >= 2^17 -> all ones.
module float_to_ufix
    import spindle_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic [31:0]             f,
    output logic [INT_W+FRAC_W-1:0] fix
);

    localparam int OW     = INT_W + FRAC_W;
    localparam int WIDE_W = MAN_W + OW;

    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] EXP_CLAMP = EXP_W'(EXP_BIAS + INT_W);
    localparam logic [EXP_W-1:0] EXP_MIN   = EXP_W'(EXP_BIAS - FRAC_W);

    logic             sgn;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] sh;

    assign {sgn, ex, man} = f;

    // Classify the operand, then scale the significand by 2^(exp-bias+FRAC_W) and drop the fraction
    always_comb begin
        sh = ex - EXP_MIN;
        if (sgn || (ex == '0) || ((ex == EXP_MAX) && (man != '0))) begin
            fix = '0;
        end else if (ex >= EXP_CLAMP) begin
            fix = '1;
        end else if (ex < EXP_MIN) begin
            fix = '0;
        end else begin
            fix = OW'((WIDE_W'({1'b1, man}) << sh) >> MAN_W);
        end
    end

endmodule

// File: rtl/afferent_spike_gen.sv
// Afferent spike generator: float rate -> fixed point, phase-accumulated into spikes and a windowed count.
// Latency: rate_valid -> rate_fix 2 cycles; tick -> spike / count_valid 1 cycle.
// Backpressure: none, strobes only. Optional refractory period under SPIKEGEN_REFRACTORY_EN.
module afferent_spike_gen
    import spindle_pkg::*;
#(
    parameter int TICK_HZ   = 1024,
    parameter int FRAC_W    = 8,
    parameter int WIN_TICKS = 1024,
    parameter int CNT_W     = 16
`ifdef SPIKEGEN_REFRACTORY_EN
    ,
    parameter int REFR_TICKS = 2
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             rate_in,
    input  logic                    rate_valid,
    input  logic                    tick,
    output logic                    spike,
    output logic [INT_W+FRAC_W-1:0] rate_fix,
    output logic [CNT_W-1:0]        count_out,
    output logic                    count_valid
);

    localparam int RW   = INT_W + FRAC_W;
    localparam int AW   = RW + 1;
    localparam int TC_W = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;

    localparam logic [AW-1:0]   THRESH    = AW'(thresh(TICK_HZ, FRAC_W));
    localparam logic [AW-1:0]   THRESH_M1 = AW'(thresh(TICK_HZ, FRAC_W) - 1);
    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(WIN_TICKS - 1);

    logic [31:0]      rate_q;
    logic             rate_q_vld;
    logic [RW-1:0]    rate_conv;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    excess;
    logic [AW-1:0]    acc_nxt;
    logic             over;
    logic             fire;
    logic             refr_block;
    logic [TC_W-1:0]  tick_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] win_inc;

    float_to_ufix #(.FRAC_W(FRAC_W)) u_conv (
        .f   (rate_q),
        .fix (rate_conv)
    );

    // Two-stage conversion pipeline: capture the float, then the converted fixed-point rate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_q     <= IEEE_ZERO;
            rate_q_vld <= 1'b0;
            rate_fix   <= '0;
        end else begin
            rate_q_vld <= rate_valid;
            if (rate_valid) begin
                rate_q <= rate_in;
            end
            if (rate_q_vld) begin
                rate_fix <= rate_conv;
            end
        end
    end

`ifdef SPIKEGEN_REFRACTORY_EN
    localparam int REFR_W = (REFR_TICKS < 4) ? 2 : $clog2(REFR_TICKS + 1);

    logic [REFR_W-1:0] refr_cnt;

    assign refr_block = (refr_cnt != '0);

    // Refractory down-counter: reloads on a spike, then burns one count per blocked tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refr_cnt <= '0;
        end else if (tick) begin
            if (fire) begin
                refr_cnt <= REFR_W'(REFR_TICKS);
            end else if (refr_block) begin
                refr_cnt <= refr_cnt - 1'b1;
            end
        end
    end
`else
    assign refr_block = 1'b0;
`endif

    // Phase step using the registered rate; the clamp keeps acc below THRESH so it never wraps
    always_comb begin
        sum     = acc + AW'(rate_fix);
        over    = (sum >= THRESH);
        fire    = over && !refr_block;
        excess  = sum - THRESH;
        acc_nxt = sum;
        if (fire) begin
            acc_nxt = (excess > THRESH_M1) ? THRESH_M1 : excess;
        end else if (over) begin
            acc_nxt = THRESH_M1;
        end
        win_inc = win_cnt;
        if (fire && (win_cnt != '1)) begin
            win_inc = win_cnt + 1'b1;
        end
    end

    // Accumulator and one-cycle spike pulse, advanced only on tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            spike <= 1'b0;
        end else begin
            spike <= tick && fire;
            if (tick) begin
                acc <= acc_nxt;
            end
        end
    end

    // Window bookkeeping: the wrapping tick publishes its own spike in count_out and restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            win_cnt     <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (tick) begin
                if (tick_cnt == TC_LAST) begin
                    tick_cnt    <= '0;
                    win_cnt     <= '0;
                    count_out   <= win_inc;
                    count_valid <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                    win_cnt  <= win_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_afferent_spike_gen.sv
// Directed bench for afferent_spike_gen: conversion vector table plus spike/window sequences.
// Latency: checks 2-cycle conversion and 1-cycle spike/count_valid timing.
// Backpressure: none exercised; the DUT has no ready signals.
module tb_afferent_spike_gen;
    import spindle_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rate_in;
    logic        rate_valid;
    logic        tick;
    logic        spike;
    logic [24:0] rate_fix;
    logic [15:0] count_out;
    logic        count_valid;

    always #5 clk = ~clk;

    afferent_spike_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rate_in     (rate_in),
        .rate_valid  (rate_valid),
        .tick        (tick),
        .spike       (spike),
        .rate_fix    (rate_fix),
        .count_out   (count_out),
        .count_valid (count_valid)
    );

    int total = 0;
    int bad   = 0;

    int          nspk;
    int          first_spk;
    int          ncv;
    int          first_cv_tick;
    int          stray;
    int          pat_err;
    logic [15:0] first_co;
    logic [15:0] last_co;
    logic        spk_hist [0:2047];

`ifdef SPIKEGEN_REFRACTORY_EN
    localparam int FAST_SPIKES = 342;
`else
    localparam int FAST_SPIKES = 1024;
`endif

    typedef struct {
        logic [31:0] rate;
        logic [24:0] fix;
    } conv_vec_t;

    conv_vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        rate_valid = 1'b0;
        tick       = 1'b0;
        rate_in    = IEEE_ZERO;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_rate(input logic [31:0] r);
        rate_in    = r;
        rate_valid = 1'b1;
        @(posedge clk); #1;
        rate_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // n ticks, one every 4 clocks; outputs sampled 1 time unit after each edge
    task automatic run_ticks(input int n);
        nspk = 0; first_spk = 0; ncv = 0; first_cv_tick = 0; stray = 0;
        first_co = '0; last_co = '0;
        for (int k = 1; k <= n; k++) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            if (k <= 2048) spk_hist[k-1] = spike;
            if (spike) begin
                nspk++;
                if (first_spk == 0) first_spk = k;
            end
            if (count_valid) begin
                ncv++;
                if (ncv == 1) begin
                    first_cv_tick = k;
                    first_co      = count_out;
                end
                last_co = count_out;
            end
            @(posedge clk); #1;
            if (spike || count_valid) stray++;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [24:0] prev_fix;
        int          first;

        vecs[0]  = '{32'h42C8_0000, 25'd25600};     // 100.0
        vecs[1]  = '{32'h47C3_5000, 25'd25600000};  // 100000.0
        vecs[2]  = '{32'hBF80_0000, 25'd0};         // -1.0
        vecs[3]  = '{32'h7FC0_0000, 25'd0};         // quiet NaN
        vecs[4]  = '{32'h3F00_0000, 25'd128};       // 0.5
        vecs[5]  = '{32'h7F80_0000, 25'h1FF_FFFF};  // +inf clamps
        vecs[6]  = '{32'h4800_0000, 25'h1FF_FFFF};  // exactly 2^17 clamps
        vecs[7]  = '{32'h47FF_FF80, 25'd33554176};  // 131071.0, largest in range
        vecs[8]  = '{32'h3B80_0000, 25'd1};         // 2^-8, one LSB
        vecs[9]  = '{32'h3B7F_FFFF, 25'd0};         // just below one LSB
        vecs[10] = '{32'h3FC0_0000, 25'd384};       // 1.5
        vecs[11] = '{32'h4049_0FDB, 25'd804};       // pi, truncated
        vecs[12] = '{32'h0000_0001, 25'd0};         // denormal
        vecs[13] = '{32'h8000_0000, 25'd0};         // -0.0
        vecs[14] = '{32'hFF80_0000, 25'd0};         // -inf
        vecs[15] = '{32'h3F80_0000, 25'd256};       // 1.0

        reset_n    = 1'b0;
        rate_in    = IEEE_ZERO;
        rate_valid = 1'b0;
        tick       = 1'b0;
        @(posedge clk); #1;
        check("reset_spike", {31'd0, spike}, 32'd0);
        check("reset_rate_fix", {7'd0, rate_fix}, 32'd0);
        check("reset_count_out", {16'd0, count_out}, 32'd0);
        check("reset_count_valid", {31'd0, count_valid}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Conversion table: old value still visible one cycle after the strobe, new value after two
        prev_fix = '0;
        for (int i = 0; i < 16; i++) begin
            rate_in    = vecs[i].rate;
            rate_valid = 1'b1;
            @(posedge clk); #1;
            rate_valid = 1'b0;
            rate_in    = 32'h4B00_0000;
            check($sformatf("conv_hold[%0d]", i), {7'd0, rate_fix}, {7'd0, prev_fix});
            @(posedge clk); #1;
            check($sformatf("conv[%0d]=%08h", i, vecs[i].rate), {7'd0, rate_fix}, {7'd0, vecs[i].fix});
            prev_fix = vecs[i].fix;
        end

        // 100 pps over one window
        do_reset();
        load_rate(32'h42C8_0000);
        run_ticks(1024);
        check("r100_first_spike_tick", first_spk, 11);
        check("r100_spikes", nspk, 100);
        check("r100_count_valid_pulses", ncv, 1);
        check("r100_count_valid_tick", first_cv_tick, 1024);
        check("r100_count_out", {16'd0, first_co}, 32'd100);
        check("r100_stray_pulses", stray, 0);

        // 100000 pps saturates at one spike per tick (or per 3 ticks with refractory)
        do_reset();
        load_rate(IEEE_100000);
        run_ticks(1024);
        pat_err = 0;
        for (int k = 0; k < 1024; k++) begin
`ifdef SPIKEGEN_REFRACTORY_EN
            if (spk_hist[k] !== ((k % 3) == 0)) pat_err++;
`else
            if (spk_hist[k] !== 1'b1) pat_err++;
`endif
        end
        check("r100k_pattern_errors", pat_err, 0);
        check("r100k_spikes", nspk, FAST_SPIKES);
        check("r100k_count_out", {16'd0, first_co}, FAST_SPIKES);
        check("r100k_count_valid_pulses", ncv, 1);

        // Negative and NaN rates produce no activity
        do_reset();
        load_rate(32'hBF80_0000);
        check("neg_rate_fix", {7'd0, rate_fix}, 32'd0);
        run_ticks(1024);
        check("neg_spikes", nspk, 0);
        check("neg_count_valid_pulses", ncv, 1);
        check("neg_count_out", {16'd0, first_co}, 32'd0);
        do_reset();
        load_rate(32'h7FC0_0000);
        check("nan_rate_fix", {7'd0, rate_fix}, 32'd0);
        run_ticks(1024);
        check("nan_spikes", nspk, 0);
        check("nan_count_out", {16'd0, last_co}, 32'd0);

        // 0.5 pps: first spike exactly on the last tick of the second window
        do_reset();
        load_rate(32'h3F00_0000);
        check("half_rate_fix", {7'd0, rate_fix}, 32'd128);
        run_ticks(2048);
        check("half_first_spike_tick", first_spk, 2048);
        check("half_spikes", nspk, 1);
        check("half_count_valid_pulses", ncv, 2);
        check("half_count_out_w1", {16'd0, first_co}, 32'd0);
        check("half_count_out_w2", {16'd0, last_co}, 32'd1);

        // Rate update coincident with a continuous tick stream: first two ticks add 0
        do_reset();
        rate_in    = 32'h42C8_0000;
        rate_valid = 1'b1;
        tick       = 1'b1;
        first      = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            rate_valid = 1'b0;
            if (n == 1) check("same_cycle_fix_t1", {7'd0, rate_fix}, 32'd0);
            if (n == 2) check("same_cycle_fix_t2", {7'd0, rate_fix}, 32'd25600);
            if (spike && (first == 0)) first = n;
        end
        tick = 1'b0;
        check("same_cycle_first_spike_tick", first, 13);

        // Reset partway through a window clears everything at once
        do_reset();
        load_rate(32'h42C8_0000);
        run_ticks(1024);
        check("pre_reset_count_out", {16'd0, count_out}, 32'd100);
        run_ticks(500);
        reset_n = 1'b0;
        #1;
        check("midreset_spike", {31'd0, spike}, 32'd0);
        check("midreset_count_out", {16'd0, count_out}, 32'd0);
        check("midreset_count_valid", {31'd0, count_valid}, 32'd0);
        check("midreset_rate_fix", {7'd0, rate_fix}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        load_rate(32'h42C8_0000);
        run_ticks(1100);
        check("post_reset_count_valid_tick", first_cv_tick, 1024);
        check("post_reset_count_out", {16'd0, first_co}, 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
